// File: rtl/phase_sequencer.sv
// Game-flow controller for SymCounter: steps each level through the prelim, game,
// answer and post periods on 1 Hz ticks, judges the level, and tracks level and symbol rate.
//
// state  | meaning
// IDLE   | waiting for startBtn after reset
// PRELIM | preliminary countdown before play
// GAME   | symbols are shown, player counts
// ANSWER | player enters an answer
// POST   | result shown; the expiring tick judges the level
// LOSE   | level failed; waits for startBtn
// WIN    | last level passed; waits for startBtn
module phase_sequencer #(
  parameter int PRELIM_SECS = 3,
  parameter int GAME_SECS   = 10,
  parameter int ANSWER_SECS = 5,
  parameter int POST_SECS   = 3,
  parameter int MAX_LEVEL   = 9,
  parameter int TOLERANCE   = 0,
  parameter int BASE_MAX    = 100000000,
  parameter int STEP        = 10000000,
  parameter int MIN_MAX     = 10000000
) (
  input  logic        Clk100M,
  input  logic        reset,
  input  logic        tick1Hz,
  input  logic        startBtn,
  input  logic [7:0]  difference,
  output logic        pre,
  output logic        game,
  output logic        answer,
  output logic        post,
  output logic        prelimSig,
  output logic        gameSig,
  output logic        answerSig,
  output logic        postSig,
  output logic        newLevel,
  output logic [3:0]  secsLeft,
  output logic [3:0]  curLevel,
  output logic [31:0] symGenMax,
  output logic        lose,
  output logic        win
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRELIM, S_GAME, S_ANSWER, S_POST, S_LOSE, S_WIN
  } state_t;

  localparam logic [3:0]  PRELIM_C = 4'(PRELIM_SECS);
  localparam logic [3:0]  GAME_C   = 4'(GAME_SECS);
  localparam logic [3:0]  ANSWER_C = 4'(ANSWER_SECS);
  localparam logic [3:0]  POST_C   = 4'(POST_SECS);
  localparam logic [3:0]  MAX_C    = 4'(MAX_LEVEL);
  localparam logic [31:0] TOL_C    = 32'(TOLERANCE);
  localparam logic [31:0] BASE_C   = 32'(BASE_MAX);
  localparam logic [31:0] STEP_C   = 32'(STEP);
  localparam logic [31:0] MIN_C    = 32'(MIN_MAX);

  state_t      state_q;
  logic [1:0]  rst_sync_q;
  logic        pre_q, game_q, answer_q, post_q;
  logic        prelim_sig_q, game_sig_q, answer_sig_q, post_sig_q, new_level_q;
  logic [3:0]  secs_q, level_q;
  logic [31:0] sym_q, sym_d, lvl_off;
  logic        lose_q, win_q;
  logic        run, pass;

  // Assertion is immediate; release takes effect only after two clean edges.
  always_ff @(posedge Clk100M or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run  = rst_sync_q[1];
  assign pass = (32'(difference) <= TOL_C);

  // Underflow of BASE - offset shows up as offset > BASE and clamps like any short value.
  always_comb begin
    lvl_off = 32'(level_q - 4'd1) * STEP_C;
    sym_d   = BASE_C - lvl_off;
    if (lvl_off > BASE_C || sym_d < MIN_C) sym_d = MIN_C;
  end

  always_ff @(posedge Clk100M or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pre_q        <= 1'b0;
      game_q       <= 1'b0;
      answer_q     <= 1'b0;
      post_q       <= 1'b0;
      prelim_sig_q <= 1'b0;
      game_sig_q   <= 1'b0;
      answer_sig_q <= 1'b0;
      post_sig_q   <= 1'b0;
      new_level_q  <= 1'b0;
      secs_q       <= 4'd0;
      level_q      <= 4'd1;
      sym_q        <= BASE_C;
      lose_q       <= 1'b0;
      win_q        <= 1'b0;
    end else if (run) begin
      prelim_sig_q <= 1'b0;
      game_sig_q   <= 1'b0;
      answer_sig_q <= 1'b0;
      post_sig_q   <= 1'b0;
      new_level_q  <= 1'b0;
      sym_q        <= sym_d;
      case (state_q)
        S_IDLE, S_LOSE, S_WIN: begin
          if (startBtn) begin
            level_q      <= 4'd1;
            lose_q       <= 1'b0;
            win_q        <= 1'b0;
            state_q      <= S_PRELIM;
            pre_q        <= 1'b1;
            prelim_sig_q <= 1'b1;
            secs_q       <= PRELIM_C;
          end
        end
        S_PRELIM: begin
          if (tick1Hz) begin
            if (secs_q != 4'd1) begin
              secs_q <= secs_q - 4'd1;
            end else begin
              state_q    <= S_GAME;
              pre_q      <= 1'b0;
              game_q     <= 1'b1;
              game_sig_q <= 1'b1;
              secs_q     <= GAME_C;
            end
          end
        end
        S_GAME: begin
          if (tick1Hz) begin
            if (secs_q != 4'd1) begin
              secs_q <= secs_q - 4'd1;
            end else begin
              state_q      <= S_ANSWER;
              game_q       <= 1'b0;
              answer_q     <= 1'b1;
              answer_sig_q <= 1'b1;
              secs_q       <= ANSWER_C;
            end
          end
        end
        S_ANSWER: begin
          if (tick1Hz) begin
            if (secs_q != 4'd1) begin
              secs_q <= secs_q - 4'd1;
            end else begin
              state_q    <= S_POST;
              answer_q   <= 1'b0;
              post_q     <= 1'b1;
              post_sig_q <= 1'b1;
              secs_q     <= POST_C;
            end
          end
        end
        S_POST: begin
          if (tick1Hz) begin
            if (secs_q != 4'd1) begin
              secs_q <= secs_q - 4'd1;
            end else begin
              post_q <= 1'b0;
              if (!pass) begin
                state_q <= S_LOSE;
                lose_q  <= 1'b1;
                secs_q  <= 4'd0;
              end else if (level_q < MAX_C) begin
                level_q      <= level_q + 4'd1;
                new_level_q  <= 1'b1;
                state_q      <= S_PRELIM;
                pre_q        <= 1'b1;
                prelim_sig_q <= 1'b1;
                secs_q       <= PRELIM_C;
              end else begin
                state_q <= S_WIN;
                win_q   <= 1'b1;
                secs_q  <= 4'd0;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pre       = pre_q;
  assign game      = game_q;
  assign answer    = answer_q;
  assign post      = post_q;
  assign prelimSig = prelim_sig_q;
  assign gameSig   = game_sig_q;
  assign answerSig = answer_sig_q;
  assign postSig   = post_sig_q;
  assign newLevel  = new_level_q;
  assign secsLeft  = secs_q;
  assign curLevel  = level_q;
  assign symGenMax = sym_q;
  assign lose      = lose_q;
  assign win       = win_q;

endmodule
